// File: rtl/tft_spi_tx_pkg.sv
// ============================================================================
// Package : tft_defs
// Shared FSM encodings and SPI/DC levels for the TFT byte serializer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package tft_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } tft_state_t;

  localparam logic DC_CMD   = 1'b0;
  localparam logic DC_DATA  = 1'b1;
  localparam logic SCK_IDLE = 1'b0;
  localparam logic CS_IDLE  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/tft_spi_tx_clk_div.sv
// ============================================================================
// Module  : spi_clk_div
// Half-period tick generator: one-cycle tick every CLK_DIV cycles, restartable.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_clk_div #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int               c_width = $clog2(CLK_DIV + 1);
  localparam logic [c_width-1:0] c_last = c_width'(CLK_DIV - 1);

  logic [c_width-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + c_width'(1);
    end
  end

  assign tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/tft_spi_tx.sv
// ============================================================================
// Module  : tft_spi_tx
// Byte serializer to a 4-wire SPI TFT panel (mode 0, MSB first, CS framed).
// Option  : TFT_SPI_HOLD_EN adds a one-byte holding register ahead of the shifter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tft_spi_tx
  import tft_defs::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tft_data,
  input  logic       tft_dc,
  input  logic       tft_transmit,
  output logic       tft_busy,
  output logic       spi_sck,
  output logic       spi_mosi,
  output logic       spi_cs,
  output logic       spi_dc
);

  localparam int                   c_gap_w    = $clog2(CS_GAP + 1);
  localparam logic [c_gap_w-1:0]   c_gap_last = c_gap_w'(CS_GAP - 1);

  tft_state_t         r_state, w_state;
  logic               r_sck, w_sck;
  logic               r_cs, w_cs;
  logic               r_dc, w_dc;
  logic [7:0]         r_shift, w_shift;
  logic [3:0]         r_half, w_half;
  logic [c_gap_w-1:0] r_gap_cnt, w_gap_cnt;

  logic       w_tick;
  logic       w_accept;
  logic       w_start;
  logic       w_gap_done;
  logic [7:0] w_start_data;
  logic       w_start_dc;

  assign w_accept   = tft_transmit && !tft_busy;
  assign w_gap_done = (r_state == ST_GAP) && (r_gap_cnt == c_gap_last);

`ifdef TFT_SPI_HOLD_EN
  logic [7:0] r_hold_data;
  logic       r_hold_dc;
  logic       r_hold_full;
  logic       w_free;

  // Shifter can take a byte this cycle: either idle or finishing its CS gap.
  assign w_free       = (r_state == ST_IDLE) || w_gap_done;
  assign w_start      = w_free && (r_hold_full || w_accept);
  assign w_start_data = r_hold_full ? r_hold_data : tft_data;
  assign w_start_dc   = r_hold_full ? r_hold_dc   : tft_dc;
  assign tft_busy     = r_hold_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_data <= '0;
      r_hold_dc   <= DC_CMD;
      r_hold_full <= 1'b0;
    end else if (w_accept && !w_free) begin
      r_hold_data <= tft_data;
      r_hold_dc   <= tft_dc;
      r_hold_full <= 1'b1;
    end else if (w_start && r_hold_full) begin
      r_hold_full <= 1'b0;
    end
  end
`else
  assign w_start      = (r_state == ST_IDLE) && w_accept;
  assign w_start_data = tft_data;
  assign w_start_dc   = tft_dc;
  assign tft_busy     = (r_state != ST_IDLE);
`endif

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .clear(w_start),
    .tick (w_tick)
  );

  always_comb begin
    w_state   = r_state;
    w_sck     = r_sck;
    w_cs      = r_cs;
    w_dc      = r_dc;
    w_shift   = r_shift;
    w_half    = r_half;
    w_gap_cnt = r_gap_cnt;

    case (r_state)
      ST_IDLE: ;
      ST_SETUP: begin
        if (w_tick) begin
          w_sck   = ~SCK_IDLE;
          w_half  = 4'd0;
          w_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Even half-periods are SCK high; half 15 is the trailing low half.
        if (w_tick) begin
          if (r_half == 4'd15) begin
            w_cs      = CS_IDLE;
            w_gap_cnt = '0;
            w_state   = ST_GAP;
          end else begin
            w_half = r_half + 4'd1;
            w_sck  = ~r_sck;
            if (r_sck) begin
              w_shift = {r_shift[6:0], 1'b0};
            end
          end
        end
      end
      ST_GAP: begin
        if (w_gap_done) begin
          w_state = ST_IDLE;
        end else begin
          w_gap_cnt = r_gap_cnt + c_gap_w'(1);
        end
      end
      default: w_state = ST_IDLE;
    endcase

    if (w_start) begin
      w_state = ST_SETUP;
      w_cs    = ~CS_IDLE;
      w_sck   = SCK_IDLE;
      w_dc    = w_start_dc;
      w_shift = w_start_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sck     <= SCK_IDLE;
      r_cs      <= CS_IDLE;
      r_dc      <= DC_CMD;
      r_shift   <= '0;
      r_half    <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state;
      r_sck     <= w_sck;
      r_cs      <= w_cs;
      r_dc      <= w_dc;
      r_shift   <= w_shift;
      r_half    <= w_half;
      r_gap_cnt <= w_gap_cnt;
    end
  end

  assign spi_sck  = r_sck;
  assign spi_cs   = r_cs;
  assign spi_dc   = r_dc;
  assign spi_mosi = r_shift[7];

endmodule

`default_nettype wire

// File: tb/tb_tft_spi_tx.sv
// ============================================================================
// Module  : tb_tft_spi_tx
// Scoreboard bench: stimulus queues expected frames, monitors decode the SPI pins.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tft_spi_tx;

  localparam int D0 = 2, G0 = 1;
  localparam int D1 = 1, G1 = 3;

  typedef struct {
    logic [7:0] data;
    logic       dc;
    int         div;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] tx  = '0;
  logic [1:0] dci = '0;
  logic [7:0] din [2] = '{8'h00, 8'h00};

  logic sck0, sck1, cs0, cs1, mosi0, mosi1, dco0, dco1, busy0, busy1;
  logic [1:0] sck, cs, mosi, dco, busy;
  assign sck  = {sck1, sck0};
  assign cs   = {cs1, cs0};
  assign mosi = {mosi1, mosi0};
  assign dco  = {dco1, dco0};
  assign busy = {busy1, busy0};

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;

  exp_t q0[$], q1[$];
  int   bq0[$], bq1[$];
  exp_t me;
  int   mb;

  // Monitor state, one slot per DUT
  logic       in_frame [2];
  logic [7:0] bits [2];
  int         nrise [2], first [2], minp [2], maxp [2], cyc [2], last_rise [2];
  int         busy_run [2], last_fall [2], prev_fall [2];
  logic       dc0 [2], dc_bad [2], edge_bad [2];
  logic       p_cs [2], p_sck [2], p_busy [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  tft_spi_tx #(.CLK_DIV(D0), .CS_GAP(G0)) dut (
    .clk(clk), .rst(rst), .tft_data(din[0]), .tft_dc(dci[0]), .tft_transmit(tx[0]),
    .tft_busy(busy0), .spi_sck(sck0), .spi_mosi(mosi0), .spi_cs(cs0), .spi_dc(dco0)
  );

  tft_spi_tx #(.CLK_DIV(D1), .CS_GAP(G1)) dut1 (
    .clk(clk), .rst(rst), .tft_data(din[1]), .tft_dc(dci[1]), .tft_transmit(tx[1]),
    .tft_busy(busy1), .spi_sck(sck1), .spi_mosi(mosi1), .spi_cs(cs1), .spi_dc(dco1)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: decode each CS frame and busy run, compare against queued expectations
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        in_frame[k] = 1'b0;
        busy_run[k] = 0;
        p_cs[k]     = 1'b1;
        p_sck[k]    = 1'b0;
        p_busy[k]   = 1'b0;
      end else begin
        if (!cs[k] && p_cs[k]) begin
          in_frame[k]  = 1'b1;
          bits[k]      = 8'h00;
          nrise[k]     = 0;
          first[k]     = -1;
          minp[k]      = 9999;
          maxp[k]      = 0;
          cyc[k]       = 0;
          dc0[k]       = dco[k];
          dc_bad[k]    = 1'b0;
          edge_bad[k]  = sck[k];
          prev_fall[k] = last_fall[k];
          last_fall[k] = cyc_cnt;
        end
        if (in_frame[k] && !cs[k]) begin
          cyc[k]++;
          if (dco[k] != dc0[k]) dc_bad[k] = 1'b1;
          if (sck[k] && !p_sck[k]) begin
            if (nrise[k] == 0) begin
              first[k] = cyc[k] - 1;
            end else begin
              if (cyc[k] - last_rise[k] < minp[k]) minp[k] = cyc[k] - last_rise[k];
              if (cyc[k] - last_rise[k] > maxp[k]) maxp[k] = cyc[k] - last_rise[k];
            end
            last_rise[k] = cyc[k];
            bits[k]      = {bits[k][6:0], mosi[k]};
            nrise[k]++;
          end
        end
        if (cs[k] && !p_cs[k] && in_frame[k]) begin
          in_frame[k] = 1'b0;
          if (sck[k]) edge_bad[k] = 1'b1;
          if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL d%0d frame: unexpected frame carrying 0x%0h, none queued", k, bits[k]);
          end else begin
            if (k == 0) me = q0.pop_front();
            else        me = q1.pop_front();
            check($sformatf("d%0d byte", k), int'(bits[k]), int'(me.data));
            check($sformatf("d%0d sck rises", k), nrise[k], 8);
            check($sformatf("d%0d dc level", k), int'(dc0[k]), int'(me.dc));
            check($sformatf("d%0d dc stable", k), int'(dc_bad[k]), 0);
            check($sformatf("d%0d sck low at cs edges", k), int'(edge_bad[k]), 0);
            check($sformatf("d%0d first rise delay", k), first[k], me.div);
            check($sformatf("d%0d sck period min", k), minp[k], 2 * me.div);
            check($sformatf("d%0d sck period max", k), maxp[k], 2 * me.div);
          end
        end
        if (busy[k]) begin
          busy_run[k]++;
        end else if (p_busy[k]) begin
          if ((k == 0 && bq0.size() == 0) || (k == 1 && bq1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL d%0d busy: unexpected busy run of %0d cycles", k, busy_run[k]);
          end else begin
            if (k == 0) mb = bq0.pop_front();
            else        mb = bq1.pop_front();
            check($sformatf("d%0d busy cycles", k), busy_run[k], mb);
          end
          busy_run[k] = 0;
        end
        p_cs[k]   = cs[k];
        p_sck[k]  = sck[k];
        p_busy[k] = busy[k];
      end
    end
  end

  task automatic send(input int k, input logic [7:0] d, input logic dc, input bit push);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (busy[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy[k]) begin
      checks++;
      errors++;
      $display("FAIL d%0d send timeout: busy still %0d after %0d cycles", k, busy[k], n);
    end
    tx[k]  = 1'b1;
    din[k] = d;
    dci[k] = dc;
    if (push) begin
      e.data = d;
      e.dc   = dc;
      e.div  = (k == 0) ? D0 : D1;
      if (k == 0) q0.push_back(e);
      else        q1.push_back(e);
`ifndef TFT_SPI_HOLD_EN
      if (k == 0) bq0.push_back(17 * D0 + G0);
      else        bq1.push_back(17 * D1 + G1);
`endif
    end
    @(posedge clk);
    #1;
    tx[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int st = 0;
    int n  = 0;
    while (st < 5 && n < 1000) begin
      @(negedge clk);
      n++;
      if (cs[k] && !busy[k]) st++;
      else st = 0;
    end
    if (st < 5) begin
      checks++;
      errors++;
      $display("FAIL d%0d idle timeout: cs=%0d busy=%0d after %0d cycles", k, cs[k], busy[k], n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int r;
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("d0 reset state {cs,sck,mosi,dc,busy}", int'({cs[0], sck[0], mosi[0], dco[0], busy[0]}), 5'b10000);
    check("d1 reset state {cs,sck,mosi,dc,busy}", int'({cs[1], sck[1], mosi[1], dco[1], busy[1]}), 5'b10000);

    send(0, 8'hA5, 1'b1, 1'b1);
    wait_idle(0);
    send(0, 8'h2C, 1'b0, 1'b1);
    wait_idle(0);

`ifdef TFT_SPI_HOLD_EN
    send(0, 8'h12, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    tx[0]  = 1'b1;
    din[0] = 8'h34;
    dci[0] = 1'b0;
    me.data = 8'h34;
    me.dc   = 1'b0;
    me.div  = D0;
    q0.push_back(me);
    bq0.push_back(17 * D0 + G0 - 2);
    @(posedge clk);
    #1;
    tx[0] = 1'b0;
    wait_idle(0);
    check("d0 back-to-back cs fall spacing", last_fall[0] - prev_fall[0], 17 * D0 + G0);
`else
    send(0, 8'h00, 1'b0, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    tx[0]  = 1'b1;
    din[0] = 8'hFF;
    @(posedge clk);
    #1;
    tx[0] = 1'b0;
    wait_idle(0);
`endif

    // Abort a byte with reset after its third SCK rise
    send(0, 8'hF0, 1'b1, 1'b0);
    r = 0;
    n = 0;
    while (r < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (sck[0] && !p_sck[0]) r++;
    end
    check("d0 sck rises before reset", r, 3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("d0 state after mid-byte reset", int'({cs[0], sck[0], mosi[0], dco[0], busy[0]}), 5'b10000);
    send(0, 8'h81, 1'b1, 1'b1);
    wait_idle(0);

    send(1, 8'h3C, 1'b1, 1'b1);
    wait_idle(1);

    repeat (5) @(negedge clk);
    check("d0 frames left in queue", q0.size(), 0);
    check("d1 frames left in queue", q1.size(), 0);
    check("d0 busy runs left in queue", bq0.size(), 0);
    check("d1 busy runs left in queue", bq1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
